// File: rtl/hex_char_rotator.sv
// rtl/hex_char_rotator.sv - four 2-bit display char codes rotated across HEX0..HEX3 at a fixed step rate
module hex_char_rotator #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] SW,
  input  logic       load,
  input  logic       run,
  input  logic       dir,
  output logic [7:0] codes,
  output logic       step,
  output logic [1:0] pos
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          cnt_en;
  logic          do_rotate;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = run ? RUN : PAUSE;
    end else begin
      case (state)
        RUN:     if (!run) state_next = PAUSE;
        PAUSE:   if (run)  state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  // Load outranks rotate, so both controls are gated off by load.
  always_comb begin
    cnt_en    = (state == RUN) && run && !load;
    do_rotate = cnt_en && tick;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      codes <= 8'hFF;
      pos   <= 2'd0;
      step  <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      codes <= SW;
      pos   <= 2'd0;
      step  <= 1'b0;
      cnt   <= '0;
    end else begin
      step <= 1'b0;
      if (do_rotate) begin
        cnt  <= '0;
        step <= 1'b1;
        if (dir) begin
          codes <= {codes[1:0], codes[7:2]};
          pos   <= pos - 2'd1;
        end else begin
          codes <= {codes[5:0], codes[7:6]};
          pos   <= pos + 2'd1;
        end
      end else if (cnt_en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_char_rotator.sv
// tb/tb_hex_char_rotator.sv - self-checking bench for hex_char_rotator with TICK_DIV=4
module tb_hex_char_rotator;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] codes;
  logic       step;
  logic [1:0] pos;

  int total = 0;
  int bad = 0;

  hex_char_rotator #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .reset(reset), .SW(sw), .load(load), .run(run), .dir(dir),
    .codes(codes), .step(step), .pos(pos)
  );

  always #5 clk = ~clk;

  // Reference: loaded pattern plus rotation offset; display i shows base char (i - offset) mod 4.
  logic [1:0] m_base [4];
  int         m_off = 0;
  bit         m_blank = 1;
  bit         m_step = 0;
  int         m_mode = 0;   // 0 idle, 1 running, 2 paused
  int         m_cnt = 0;

  function automatic logic [7:0] m_codes();
    logic [7:0] c;
    if (m_blank) return 8'hFF;
    for (int i = 0; i < 4; i++) c[2*i +: 2] = m_base[(i - m_off) & 3];
    return c;
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit rn, input bit d, input logic [7:0] s);
    if (r) begin
      m_blank = 1; m_off = 0; m_step = 0; m_cnt = 0; m_mode = 0;
    end else if (l) begin
      for (int i = 0; i < 4; i++) m_base[i] = s[2*i +: 2];
      m_blank = 0; m_off = 0; m_step = 0; m_cnt = 0;
      m_mode = rn ? 1 : 2;
    end else begin
      m_step = 0;
      if (m_mode == 1) begin
        if (!rn) m_mode = 2;
        else if (m_cnt == TD - 1) begin
          m_cnt = 0; m_step = 1;
          m_off = d ? (m_off + 3) % 4 : (m_off + 1) % 4;
        end else m_cnt++;
      end else if (m_mode == 2 && rn) m_mode = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit rn, input bit d, input logic [7:0] s);
    reset = r; load = l; run = rn; dir = d; sw = s;
    @(posedge clk);
    model_edge(r, l, rn, d, s);
    #1;
    check("model", {codes, step, pos}, {m_codes(), m_step, m_off[1:0]});
  endtask

  typedef struct {
    bit         ld;
    bit         rn;
    bit         dr;
    logic [7:0] s;
    logic [7:0] exp_codes;
    bit         exp_step;
    logic [1:0] exp_pos;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1, 1, 0, 8'hE4, 8'hE4, 0, 2'd0};
    tbl[1] = '{0, 1, 0, 8'h00, 8'hE4, 0, 2'd0};
    tbl[2] = '{0, 1, 0, 8'h00, 8'hE4, 0, 2'd0};
    tbl[3] = '{0, 1, 0, 8'h00, 8'hE4, 0, 2'd0};
    tbl[4] = '{0, 1, 0, 8'h00, 8'h93, 1, 2'd1};
    tbl[5] = '{0, 1, 0, 8'h00, 8'h93, 0, 2'd1};
    tbl[6] = '{0, 1, 0, 8'h00, 8'h93, 0, 2'd1};
    tbl[7] = '{0, 1, 0, 8'h00, 8'h93, 0, 2'd1};
    tbl[8] = '{0, 1, 0, 8'h00, 8'h4E, 1, 2'd2};

    // 1: reset, then run in IDLE changes nothing
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    check("reset_state", {codes, step, pos}, {8'hFF, 1'b0, 2'd0});
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'h00);
    check("idle_blank", {codes, step, pos}, {8'hFF, 1'b0, 2'd0});

    // 2: table-driven left rotation
    for (int i = 0; i < 9; i++) begin
      cyc(0, tbl[i].ld, tbl[i].rn, tbl[i].dr, tbl[i].s);
      check($sformatf("tbl%0d", i), {codes, step, pos},
            {tbl[i].exp_codes, tbl[i].exp_step, tbl[i].exp_pos});
    end

    // 3: right rotation with pos wrap 0->3, four steps return home
    cyc(0, 1, 1, 1, 8'hE4);
    for (int i = 0; i < TD; i++) cyc(0, 0, 1, 1, 8'h00);
    check("right_first", {codes, step, pos}, {8'h39, 1'b1, 2'd3});
    for (int i = 0; i < 3 * TD; i++) cyc(0, 0, 1, 1, 8'h00);
    check("right_home", {codes, step, pos}, {8'hE4, 1'b1, 2'd0});

    // 4: run drops in the tick cycle, resumes later
    cyc(0, 1, 1, 0, 8'hE4);
    for (int i = 0; i < TD - 1; i++) cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    check("pause_tick", {codes, step, pos}, {8'hE4, 1'b0, 2'd0});
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    check("resume_edge", {codes, step}, {8'hE4, 1'b0});
    cyc(0, 0, 1, 0, 8'h00);
    check("resume_step", {codes, step, pos}, {8'h93, 1'b1, 2'd1});

    // 5: load collides with tick
    cyc(0, 1, 1, 0, 8'hE4);
    for (int i = 0; i < TD - 1; i++) cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'h1B);
    check("load_tick", {codes, step, pos}, {8'h1B, 1'b0, 2'd0});
    for (int i = 0; i < TD - 1; i++) cyc(0, 0, 1, 0, 8'h00);
    check("load_nostep", {1'b0, step}, 2'b00);
    cyc(0, 0, 1, 0, 8'h00);
    check("load_next_step", {codes, step, pos}, {8'h6C, 1'b1, 2'd1});

    // 6: reset mid-run discards the pattern
    cyc(0, 1, 1, 0, 8'hE4);
    for (int i = 0; i < TD + 2; i++) cyc(0, 0, 1, 0, 8'h00);
    cyc(1, 0, 1, 0, 8'h00);
    check("midrun_reset", {codes, step, pos}, {8'hFF, 1'b0, 2'd0});
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'h00);
    check("after_reset", {codes, step, pos}, {8'hFF, 1'b0, 2'd0});

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 80,
          $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
